load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding word-bus access, big-endian lanes.
// Optional MISALIGN_TRAP_EN: misaligned half/word errors instead of aligning down.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic        ld_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] load_q;

  logic        is_b, is_h, is_w;
  logic        legal, trap_hit;
  logic [1:0]  off;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext_v;

  assign is_b = funct3[1:0] == 2'b00;
  assign is_h = funct3[1:0] == 2'b01;
  assign is_w = funct3[1:0] == 2'b10;

  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = is_load;
      default:                legal = 1'b0;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign trap_hit = (is_h & addr[0]) | (is_w & (|addr[1:0]));
  assign off      = addr[1:0];
`else
  assign trap_hit = 1'b0;
  always_comb begin
    off = addr[1:0];
    if (is_h) off[0] = 1'b0;
    if (is_w) off = 2'b00;
  end
`endif

  // Lane 0 of the word is the most significant byte
  always_comb begin
    be_d    = 4'b0000;
    wdata_d = 32'h0;
    unique case (1'b1)
      is_b: begin
        be_d    = 4'b1000 >> off;
        wdata_d = {4{store_data[7:0]}};
      end
      is_h: begin
        be_d    = off[1] ? 4'b0011 : 4'b1100;
        wdata_d = {2{store_data[15:0]}};
      end
      is_w: begin
        be_d    = 4'b1111;
        wdata_d = store_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (legal && !trap_hit) ? REQ : ERR;
      REQ: begin
        if (mem_ack)                       state_d = DONE;
        else if (cnt_q == 8'(TIMEOUT - 1)) state_d = ERR;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign byte_v = 8'(mem_rdata >> {~off_q, 3'b000});
  assign half_v = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];

  always_comb begin
    ext_v = mem_rdata;
    case (f3_q)
      3'b000:  ext_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  ext_v = {{16{half_v[15]}}, half_v};
      3'b100:  ext_v = {24'h0, byte_v};
      3'b101:  ext_v = {16'h0, half_v};
      default: ext_v = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'h0;
      ld_q    <= 1'b0;
      f3_q    <= 3'b0;
      off_q   <= 2'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'b0;
      load_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == REQ) begin
        cnt_q   <= 8'h0;
        ld_q    <= is_load;
        f3_q    <= funct3;
        off_q   <= off;
        addr_q  <= {addr[31:2], 2'b00};
        wdata_q <= wdata_d;
        be_q    <= be_d;
      end
      if (state_q == REQ) begin
        if (!mem_ack) cnt_q <= cnt_q + 8'h1;
        if (mem_ack && ld_q) load_q <= ext_v;
      end
    end
  end

  assign busy      = state_q == REQ;
  assign done      = (state_q == DONE) || (state_q == ERR);
  assign error     = state_q == ERR;
  assign mem_req   = state_q == REQ;
  assign mem_we    = (state_q == REQ) && !ld_q;
  assign mem_be    = (state_q == REQ) ? be_q : 4'b0000;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign load_data = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected completions queued at issue.
// Drives on negedge, samples on negedge.
module tb_load_store_unit;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        busy, done, error;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .busy(busy), .done(done), .error(error), .load_data(load_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        err;
    bit        chk_ld;
    bit [31:0] ld;
    int        done_c;
    int        reqs;
  } exp_t;

  exp_t      sb_q[$];
  int        n_checks = 0;
  int        n_err = 0;
  bit [31:0] last_ld = 32'h0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(string tag, bit ld, bit [2:0] f3,
                        bit [31:0] a, bit [31:0] sd, bit [31:0] rd,
                        int dly, bit ereq, bit [31:0] eaddr,
                        bit [3:0] ebe, bit [31:0] ewd,
                        bit eerr, bit [31:0] eld);
    exp_t e, o;
    int   reqs;
    bit   got;
    e.err    = eerr;
    e.chk_ld = ld || eerr;
    e.ld     = (ld && !eerr) ? eld : last_ld;
    e.reqs   = ereq ? ((dly < 0) ? TO : dly + 1) : 0;
    e.done_c = ereq ? e.reqs : 0;
    if (ld && !eerr) last_ld = eld;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1; is_load = ld; funct3 = f3;
    addr = a; store_data = sd;
    @(negedge clk);
    start = 1'b0;
    addr = $urandom; store_data = $urandom;
    is_load = ~ld; funct3 = 3'b010;
    check({tag, "/req_lat"}, {31'b0, mem_req}, {31'b0, ereq});
    reqs = 0;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (mem_req) begin
        if (reqs == 0) begin
          check({tag, "/busy"}, {31'b0, busy}, 32'd1);
          check({tag, "/we"}, {31'b0, mem_we}, {31'b0, !ld});
          check({tag, "/maddr"}, mem_addr, eaddr);
          check({tag, "/be"}, {28'b0, mem_be}, {28'b0, ebe});
          if (!ld) check({tag, "/wdata"}, mem_wdata, ewd);
        end
        mem_ack = (dly >= 0) && (reqs == dly);
        mem_rdata = mem_ack ? rd : $urandom;
        reqs++;
      end else begin
        mem_ack = 1'b0;
      end
      if (done) begin
        got = 1'b1;
        o = sb_q.pop_front();
        check({tag, "/error"}, {31'b0, error}, {31'b0, o.err});
        if (o.chk_ld) check({tag, "/ldata"}, load_data, o.ld);
        check({tag, "/done_cyc"}, c, o.done_c);
        check({tag, "/req_cnt"}, reqs, o.reqs);
      end else begin
        @(negedge clk);
      end
    end
    mem_ack = 1'b0;
    if (!got) begin
      check({tag, "/no_done"}, 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end
    @(negedge clk);
    check({tag, "/idle"}, {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ctl", {27'b0, busy, done, error, mem_req, mem_we}, 32'd0);
    check("rst_be", {28'b0, mem_be}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_ldata", load_data, 32'd0);
    reset = 1'b0;

    run_op("sb_0a", 0, 3'b000, 32'h0A, 32'h0004567F, 0, 0,
           1, 32'h08, 4'b0010, 32'h7F7F7F7F, 0, 0);
    run_op("lb_05", 1, 3'b000, 32'h05, 0, 32'h12F03456, 0,
           1, 32'h04, 4'b0100, 0, 0, 32'hFFFFFFF0);
    run_op("lbu_05", 1, 3'b100, 32'h05, 0, 32'h12F03456, 1,
           1, 32'h04, 4'b0100, 0, 0, 32'h000000F0);
    run_op("lh_02", 1, 3'b001, 32'h02, 0, 32'hDEAD8001, 0,
           1, 32'h00, 4'b0011, 0, 0, 32'hFFFF8001);
    run_op("lhu_00", 1, 3'b101, 32'h100, 0, 32'hDEAD8001, 2,
           1, 32'h100, 4'b1100, 0, 0, 32'h0000DEAD);
    run_op("lw_14", 1, 3'b010, 32'h14, 0, 32'hDEADBEEF, 3,
           1, 32'h14, 4'b1111, 0, 0, 32'hDEADBEEF);
    run_op("tmo", 1, 3'b010, 32'h20, 0, 0, -1,
           1, 32'h20, 4'b1111, 0, 1, 0);
    run_op("sh_02", 0, 3'b001, 32'h02, 32'h1234ABCD, 0, 0,
           1, 32'h00, 4'b0011, 32'hABCDABCD, 0, 0);
    run_op("sw_10", 0, 3'b010, 32'h10, 32'hCAFEF00D, 0, 1,
           1, 32'h10, 4'b1111, 32'hCAFEF00D, 0, 0);
    run_op("sb_03", 0, 3'b000, 32'h03, 32'hAABBCC55, 0, 0,
           1, 32'h00, 4'b0001, 32'h55555555, 0, 0);
    run_op("sbu_ill", 0, 3'b100, 32'h08, 32'h1, 0, 0,
           0, 0, 0, 0, 1, 0);
    run_op("ld011_ill", 1, 3'b011, 32'h08, 0, 0, 0,
           0, 0, 0, 0, 1, 0);
`ifdef MISALIGN_TRAP_EN
    run_op("lw_06", 1, 3'b010, 32'h06, 0, 32'h11223344, 0,
           0, 0, 0, 0, 1, 0);
    run_op("lh_03", 1, 3'b001, 32'h03, 0, 32'h11223344, 0,
           0, 0, 0, 0, 1, 0);
`else
    run_op("lw_06", 1, 3'b010, 32'h06, 0, 32'h11223344, 0,
           1, 32'h04, 4'b1111, 0, 0, 32'h11223344);
    run_op("lh_03", 1, 3'b001, 32'h03, 0, 32'h11228344, 0,
           1, 32'h00, 4'b0011, 0, 0, 32'hFFFF8344);
`endif

    @(negedge clk);
    start = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h40;
    @(negedge clk);
    start = 1'b0;
    check("rst_mid/req1", {31'b0, mem_req}, 32'd1);
    @(negedge clk);
    check("rst_mid/req2", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid/drop", {30'b0, mem_req, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    last_ld = 32'h0;
    run_op("post_rst", 1, 3'b010, 32'h44, 0, 32'hA5A55A5A, 0,
           1, 32'h44, 4'b1111, 0, 0, 32'hA5A55A5A);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
